apb_master: RTL and testbench

//  APB requester; the initiating end for the team's 8-bit APB slaves.

---
 rtl/apb_master_pkg.sv | 11 +
 rtl/apb_master_if.sv | 31 +++
 rtl/apb_master_wdog_cnt.sv | 18 +
 rtl/apb_master.sv | 75 +++++++
 tb/tb_apb_master.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared widths and FSM state encodings for the APB requester
package apb_master_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   typedef logic [2:0] state_t;
   localparam state_t IDLE    = 3'd0;
   localparam state_t SETUP   = 3'd1;
   localparam state_t ACCESS  = 3'd2;
   localparam state_t CAPTURE = 3'd3;
   localparam state_t RESP    = 3'd4;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command/response stream plus APB bus signals between requester and its peers
interface apb_master_if
   import apb_master_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master_wdog_cnt.sv
// apb_master_wdog_cnt: saturating ACCESS-wait counter flagging when the stall budget is spent
module apb_master_wdog_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic pclk,
   input  logic preset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   assign expired = (cnt == CW'(TIMEOUT - 1));
   // count stalled cycles, holding at the expiry value so the counter never wraps
   always_ff @(posedge pclk)
      if (preset || clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command stream into single-outstanding APB transfers with timeout
module apb_master
   import apb_master_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RD_LAG  = 1,
   parameter int TIMEOUT = 16
) (
   input logic          pclk,
   input logic          preset,
   apb_master_if.master bus
);
   state_t state;
   logic   expired;
   assign bus.cmd_ready = (state == IDLE);
   apb_master_wdog_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
      .pclk    (pclk),
      .preset  (preset),
      .clr     (state == SETUP),
      .en      (state == ACCESS && !bus.pready),
      .expired (expired)
   );
   // transfer sequencing; every bus and response output is registered here
   always_ff @(posedge pclk)
      if (preset) begin
         state         <= IDLE;
         bus.psel      <= 1'b0;
         bus.penable   <= 1'b0;
         bus.pwrite    <= 1'b0;
         bus.paddr     <= '0;
         bus.pwdata    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= (state == RESP);
         case (state)
            IDLE:
               if (bus.cmd_valid) begin
                  bus.psel   <= 1'b1;
                  bus.pwrite <= bus.cmd_write;
                  bus.paddr  <= bus.cmd_addr;
                  bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                  state      <= SETUP;
               end
            SETUP: begin
               bus.penable <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS:
               if (bus.pready) begin
                  bus.psel    <= 1'b0;
                  bus.penable <= 1'b0;
                  bus.rsp_err <= 1'b0;
                  if (bus.pwrite || RD_LAG == 0) begin
                     bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
                     state         <= RESP;
                  end else state <= CAPTURE;
               end else if (expired) begin
                  bus.psel      <= 1'b0;
                  bus.penable   <= 1'b0;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
                  state         <= RESP;
               end
            CAPTURE: begin
               bus.rsp_rdata <= bus.prdata;
               state         <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of the APB requester with RD_LAG=1, TIMEOUT=16
module tb_apb_master;
   logic pclk = 1'b0;
   logic preset = 1'b1;
   int nvec = 0;
   int nerr = 0;
   int cnt, nacc, nrsp;
   logic acc;
   logic       cw[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] ca[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
   logic [7:0] cd[4] = '{8'h11, 8'h00, 8'h33, 8'h00};
   logic [7:0] er[4] = '{8'h00, 8'hA7, 8'h00, 8'hA1};

   apb_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();
   apb_master #(.ADDR_W(8), .DATA_W(8), .RD_LAG(1), .TIMEOUT(16)) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus.master)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_wdata = 8'h00;
      bus.pready    = 1'b0;
      bus.prdata    = 8'h00;
      tick();
      tick();
      preset = 1'b0;
      chk("rst_psel", bus.psel, 0);
      chk("rst_penable", bus.penable, 0);
      chk("rst_pwrite", bus.pwrite, 0);
      chk("rst_paddr", bus.paddr, 0);
      chk("rst_pwdata", bus.pwdata, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);

      issue(1'b1, 8'h10, 8'h5A);
      bus.pready = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      chk("wr_setup_psel", bus.psel, 1);
      chk("wr_setup_penable", bus.penable, 0);
      chk("wr_setup_paddr", bus.paddr, 8'h10);
      chk("wr_setup_pwrite", bus.pwrite, 1);
      chk("wr_setup_pwdata", bus.pwdata, 8'h5A);
      chk("wr_setup_cmd_ready", bus.cmd_ready, 0);
      tick();
      chk("wr_access_penable", bus.penable, 1);
      chk("wr_access_psel", bus.psel, 1);
      tick();
      chk("wr_done_psel", bus.psel, 0);
      chk("wr_done_penable", bus.penable, 0);
      chk("wr_done_rsp_early", bus.rsp_valid, 0);
      tick();
      chk("wr_rsp_valid", bus.rsp_valid, 1);
      chk("wr_rsp_err", bus.rsp_err, 0);
      chk("wr_rsp_rdata", bus.rsp_rdata, 0);
      chk("wr_rsp_cmd_ready", bus.cmd_ready, 1);
      tick();
      chk("wr_rsp_pulse", bus.rsp_valid, 0);

      issue(1'b0, 8'h10, 8'hFF);
      tick();
      bus.cmd_valid = 1'b0;
      chk("rd_setup_pwrite", bus.pwrite, 0);
      chk("rd_setup_pwdata", bus.pwdata, 0);
      chk("rd_setup_paddr", bus.paddr, 8'h10);
      tick();
      chk("rd_access_penable", bus.penable, 1);
      tick();
      chk("rd_capture_psel", bus.psel, 0);
      bus.prdata = 8'h5A;
      tick();
      chk("rd_capture_no_rsp", bus.rsp_valid, 0);
      bus.prdata = 8'h77;
      tick();
      chk("rd_rsp_valid", bus.rsp_valid, 1);
      chk("rd_rsp_rdata", bus.rsp_rdata, 8'h5A);
      chk("rd_rsp_err", bus.rsp_err, 0);

      issue(1'b0, 8'h44, 8'h00);
      bus.pready = 1'b0;
      bus.prdata = 8'hEE;
      tick();
      bus.cmd_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40 && !bus.rsp_valid; i++) begin
         tick();
         if (bus.penable) cnt++;
      end
      chk("to_access_cycles", cnt, 16);
      chk("to_rsp_valid", bus.rsp_valid, 1);
      chk("to_rsp_err", bus.rsp_err, 1);
      chk("to_rsp_rdata", bus.rsp_rdata, 0);
      chk("to_psel", bus.psel, 0);

      issue(1'b1, 8'h33, 8'hC3);
      tick();
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("st_penable", bus.penable, 1);
         chk("st_paddr", bus.paddr, 8'h33);
         chk("st_pwdata", bus.pwdata, 8'hC3);
         if (i == 3) bus.pready = 1'b1;
      end
      tick();
      chk("st_release", bus.penable, 0);
      tick();
      chk("st_rsp_valid", bus.rsp_valid, 1);
      chk("st_rsp_err", bus.rsp_err, 0);

      issue(1'b1, 8'h55, 8'h99);
      bus.pready = 1'b0;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      chk("rs_access_penable", bus.penable, 1);
      preset = 1'b1;
      tick();
      preset = 1'b0;
      chk("rs_psel", bus.psel, 0);
      chk("rs_penable", bus.penable, 0);
      chk("rs_paddr", bus.paddr, 0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.rsp_valid) cnt++;
         tick();
      end
      chk("rs_no_rsp", cnt, 0);
      chk("rs_cmd_ready", bus.cmd_ready, 1);

      nacc = 0;
      nrsp = 0;
      bus.pready = 1'b1;
      issue(cw[0], ca[0], cd[0]);
      for (int i = 0; i < 30; i++) begin
         acc = bus.cmd_valid && bus.cmd_ready;
         tick();
         bus.prdata = bus.paddr ^ 8'hA5;
         if (acc) begin
            nacc++;
            if (nacc < 4) issue(cw[nacc], ca[nacc], cd[nacc]);
            else bus.cmd_valid = 1'b0;
         end
         if (bus.rsp_valid) begin
            if (nrsp < 4) chk("b2b_rdata", bus.rsp_rdata, er[nrsp]);
            nrsp++;
         end
      end
      chk("b2b_accepts", nacc, 4);
      chk("b2b_rsps", nrsp, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
